// File: rtl/mdu_divider_pkg.sv
// Shared defines for the EX-stage multiply/divide unit: divider state encodings,
// iteration count and the ALU op codes that steer DIV/DIVU results to HI/LO.
package mdu_divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;
  localparam int unsigned DIV_ITER  = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ON   = 2'd1,
    DIV_END  = 2'd2
  } div_state_e;

  // ALU op codes (funct-derived); DIV/DIVU live next to the multiply ops.
  localparam logic [7:0] EXE_MULT_OP  = 8'h18;
  localparam logic [7:0] EXE_MULTU_OP = 8'h19;
  localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
  localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;

endpackage

// File: rtl/mdu_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
  import mdu_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The kept difference is always below the divisor, so WIDTH bits hold it.
  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, divisor_i});
    diff    = shifted[WIDTH-1:0] - divisor_i;
    rem_o   = qbit_o ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; divres_o = {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: a zero divisor completes one cycle after acceptance.
module mdu_divider
  import mdu_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] divres_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   raw_q, raw_d;
  logic               zero_q, zero_d;
  logic               dsign_q, dsign_d;
  logic               qsign_q, qsign_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] divres_q, divres_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_qbit;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .divisor_i(dvs_q),
    .bit_i    (dvd_q[WIDTH-1]),
    .rem_o    (step_rem),
    .qbit_o   (step_qbit)
  );

  // dvd_q shifts the dividend out MSB-first while quotient bits shift in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    raw_d    = raw_q;
    zero_d   = zero_q;
    dsign_d  = dsign_q;
    qsign_d  = qsign_q;
    divres_d = divres_q;

    case (state_q)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          dsign_d = signed_i & dividend_i[WIDTH-1];
          qsign_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
          dvd_d   = cneg(dividend_i, dsign_d);
          dvs_d   = cneg(divisor_i, signed_i & divisor_i[WIDTH-1]);
          rem_d   = '0;
          raw_d   = dividend_i;
          zero_d  = (divisor_i == '0);
          cnt_d   = '0;
`ifdef DIV_ZERO_FAST_EN
          if (zero_d) begin
            state_d  = DIV_END;
            divres_d = {dividend_i, {WIDTH{1'b1}}};
          end else begin
            state_d = DIV_ON;
          end
`else
          state_d = DIV_ON;
`endif
        end
      end
      DIV_ON: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d  = DIV_END;
          divres_d = zero_q ? {raw_q, {WIDTH{1'b1}}}
                            : {cneg(step_rem, dsign_q), cneg(dvd_d, qsign_q)};
        end
      end
      DIV_END: state_d = DIV_IDLE;
      default: state_d = DIV_IDLE;
    endcase

    // Flush/exception wins over everything and leaves the last result intact.
    if (annul_i) begin
      state_d  = DIV_IDLE;
      divres_d = divres_q;
    end

    busy_d  = (state_d != DIV_IDLE);
    ready_d = (state_d == DIV_END);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      raw_q    <= '0;
      zero_q   <= 1'b0;
      dsign_q  <= 1'b0;
      qsign_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      divres_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      raw_q    <= raw_d;
      zero_q   <= zero_d;
      dsign_q  <= dsign_d;
      qsign_q  <= qsign_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      divres_q <= divres_d;
    end
  end

  assign busy_o   = busy_q;
  assign ready_o  = ready_q;
  assign divres_o = divres_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed bench for mdu_divider with hand-computed {remainder, quotient} results
// and latency checks; zero-divisor latency follows DIV_ZERO_FAST_EN.
module tb_mdu_divider;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] divres_o;

  int n_vec;
  int n_err;

  mdu_divider dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .annul_i   (annul_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .divres_o  (divres_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a start for one edge, then scramble operands to prove they are latched.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    signed_i   = ~sgn;
    dividend_i = $urandom();
    divisor_i  = $urandom();
  endtask

  task automatic wait_ready(output int lat);
    lat = 1;
    while (!ready_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(sgn, a, b);
    check({tag, " busy"}, 64'(busy_o), 64'd1);
    wait_ready(lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, divres_o, exp);
    @(posedge clk);
    #1;
    check({tag, " idle after"}, {62'd0, busy_o, ready_o}, 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    n_vec      = 0;
    n_err      = 0;
    resetn     = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    annul_i    = 1'b0;

    #12;
    check("reset flags", {62'd0, busy_o, ready_o}, 64'd0);
    check("reset divres", divres_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run("divu 100/7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    run("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    run("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33);
    run("divu 5/0", 1'b0, 32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF}, ZLAT);
    run("div -8/0", 1'b1, 32'hFFFF_FFF8, 32'd0, {32'hFFFF_FFF8, 32'hFFFF_FFFF}, ZLAT);
    run("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33);

    // Annul at step 10: no pulse, result from previous divide retained.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul flags", {62'd0, busy_o, ready_o}, 64'd0);
    check("annul divres", divres_o, {32'h1, 32'hFFFF_FFFD});
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen++;
    end
    check("annul no ready", 64'(seen), 64'd0);
    run("divu 9/3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

    // Annul together with start in IDLE blocks acceptance.
    @(negedge clk);
    start_i    = 1'b1;
    annul_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    check("annul+start busy", 64'(busy_o), 64'd0);

    // A second start during DIV_ON must not disturb the running operation.
    issue(1'b0, 32'd20, 32'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start_i    = 1'b1;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_ready(lat);
    check("restart latency", 64'(lat), 64'd29);
    check("restart result", divres_o, {32'h2, 32'h3});
    @(posedge clk);
    #1;
    check("restart idle", {62'd0, busy_o, ready_o}, 64'd0);

    // Asynchronous reset mid-operation.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("async rst flags", {62'd0, busy_o, ready_o}, 64'd0);
    check("async rst divres", divres_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run("divu 0/4", 1'b0, 32'd0, 32'd4, 64'd0, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
